shift_pipe: RTL and testbench
=============================

# shift_pipe

Parametrised, pipelined barrel shifter that replaces the single-position combinational shift mux chain in the ALU shift path. Each operation takes a full shift amount (0..WIDTH-1) and one of five modes: rotate left/right, logical shift left/right, and the new arithmetic shift right. The block is built as log2(WIDTH) registered stages, one per amount bit, with valid/ready handshakes on both sides. It accepts one operation per cycle when not back-pressured.

## Interface
- `WIDTH`, 16: data width; power of two, 4..64.
- `SHW`, $clog2(WIDTH): shift-amount width; derived, never overridden.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input operation present.
- `in_ready` out 1: block accepts input this cycle.
- `in_data` in WIDTH: operand.
- `in_amt` in SHW: shift amount.
- `in_op` in 3: mode select.
  - 000 ROL, 001 SLL, 010 ROR, 011 SRL, 100 SRA.
  - 101..111 are reserved.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer accepts result.
- `out_data` out WIDTH: result.
- `out_err` out 1: result came from a reserved op.

## Operation
- Stage k (k = 0..SHW-1) shifts by 2^k when amount bit k is 1; otherwise it passes data unchanged.
- Each stage carries data, amount, op, err and a valid bit in registers.
- Mode rules per stage (shift distance d = 2^k):
  - ROL: data = {data[W-1-d:0], data[W-1:W-d]}.
  - SLL: data = {data[W-1-d:0], d zeros}.
  - ROR: data = {data[d-1:0], data[W-1:d]}.
  - SRL: data = {d zeros, data[W-1:d]}.
  - SRA: data = {d copies of data[W-1], data[W-1:d]}.
- The composite result equals a single shift by `in_amt`. Amount 0 returns `in_data` unchanged in every mode.
- Reserved op: data passes through unshifted and err=1 travels with it. No other side effect.
- Handshake:
  - A transfer occurs on a cycle where valid and ready are both 1.
  - Stage k is ready when its valid is 0 or stage k+1 is ready. Stage SHW's ready is `out_ready`.
  - `in_ready` = ready of stage 0. It is combinational and has no combinational path from `in_valid`.
  - When `out_valid`=1 and `out_ready`=0, `out_data`, `out_err` and `out_valid` hold stable until accepted.
  - Bubbles collapse: a stalled output does not stall an empty upstream stage.
- Ordering: results leave in acceptance order. Never dropped, duplicated or reordered.
- Reset:
  - All stage valid bits clear asynchronously; `out_valid`=0, `out_data`=0, `out_err`=0.
  - `in_ready` reads 1 once all valids are clear.
  - Operations in flight when reset asserts are discarded. No result for them appears after reset releases.

## Timing
- Latency: SHW cycles from input acceptance to `out_valid` (4 cycles at WIDTH=16), assuming no back-pressure.
- Throughput: one operation per cycle while `out_ready`=1.
- Full pipeline with `out_ready`=0: SHW operations are held and `in_ready`=0.
  - When `out_ready` rises, `in_ready` rises in the same cycle (combinational ready chain).
  - Accept and retire happen in the same cycle.
- Each stage register is clocked only when that stage advances.
- There is no combinational path from `in_data`, `in_amt` or `in_op` to any output.

## Structure
- Package `shift_pkg`:
  - Enum `shift_op_t` (ROL, SLL, ROR, SRL, SRA), with reserved codes flagged.
  - Function `is_reserved(op)`.
  - Localparam `OP_W` = 3.
- Sub-module `shift_stage`, parameters WIDTH and DIST:
  - Combinational shift by DIST selected by op and amount bit, plus the stage register.
  - Valid/ready pair on each side.
- `shift_pipe` generates SHW instances with DIST = 1, 2, 4, ...

## Test plan
- Every mode, single operations at WIDTH=16, `out_ready`=1:
  - ROL 0x8001 amt 1 -> 0x0003.
  - ROR 0x0001 amt 1 -> 0x8000.
  - SLL 0x00FF amt 4 -> 0x0FF0.
  - SRL 0x8000 amt 15 -> 0x0001.
  - SRA 0x8000 amt 4 -> 0xF800.
  - Each result appears with `out_valid` exactly 4 cycles after acceptance.
- Amount 0 and reserved op:
  - SRA 0x1234 amt 0 -> 0x1234, err=0.
  - Op 110, 0xBEEF amt 5 -> 0xBEEF, err=1.
- Back-pressure:
  - Stream 6 ops with `out_ready`=0 -> 4 accepted, `in_ready`=0, `out_data` stable.
  - Raise `out_ready` -> all 6 results in order, none lost.
- Bubbles:
  - Alternate `in_valid` 1/0 while `out_ready` is held low after the first result -> upstream bubbles fill.
  - `in_ready` stays 1 until the 4 stage slots hold valid ops.
- Reset mid-flight: assert `rst` with 3 ops in flight.
  - `out_valid`=0 immediately, and no stale result after release.
  - The next op SLL 0x0001 amt 3 -> 0x0008.
- WIDTH=32 instance: random data/amt/op against a behavioural reference model for 10k ops with random `out_ready`. Zero mismatches.

Source files
------------

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - op encoding and helpers shared by the shift pipeline
// Contents: OP_W (op field width), shift_op_t (mode encoding, 101..111 reserved),
//           is_reserved() (flags the reserved codes).
package shift_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ROL  = 3'b000,
    OP_SLL  = 3'b001,
    OP_ROR  = 3'b010,
    OP_SRL  = 3'b011,
    OP_SRA  = 3'b100,
    OP_RSV5 = 3'b101,
    OP_RSV6 = 3'b110,
    OP_RSV7 = 3'b111
  } shift_op_t;

  function automatic logic is_reserved(input shift_op_t op);
    return (op == OP_RSV5) || (op == OP_RSV6) || (op == OP_RSV7);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one registered barrel-shifter stage shifting by DIST
// Ports: clk, rst            clock, async active-high reset
//        up_valid/up_ready   upstream handshake; up_data/up_amt/up_op/up_err payload
//        dn_valid/dn_ready   downstream handshake; dn_data/dn_amt/dn_op/dn_err payload
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIST  = 1,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  input  logic [SHW-1:0]   up_amt,
  input  shift_op_t        up_op,
  input  logic             up_err,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data,
  output logic [SHW-1:0]   dn_amt,
  output shift_op_t        dn_op,
  output logic             dn_err
);

  // Amount bit that enables this stage's shift.
  localparam int BIT = $clog2(DIST);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [SHW-1:0]   amt_q;
  shift_op_t        op_q;
  logic             err_q;
  logic [WIDTH-1:0] shifted;
  logic             load;

  // An empty slot always accepts, so bubbles collapse under a stalled output.
  assign up_ready = !valid_q || dn_ready;
  assign load     = up_valid && up_ready;

  always_comb begin
    shifted = up_data;
    if (up_amt[BIT] && !up_err) begin
      case (up_op)
        OP_ROL:  shifted = (up_data << DIST) | (up_data >> (WIDTH - DIST));
        OP_SLL:  shifted = up_data << DIST;
        OP_ROR:  shifted = (up_data >> DIST) | (up_data << (WIDTH - DIST));
        OP_SRL:  shifted = up_data >> DIST;
        OP_SRA:  shifted = $signed(up_data) >>> DIST;
        default: shifted = up_data;
      endcase
    end
  end

  // Valid follows the upstream whenever this slot is free or draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (up_ready) begin
      valid_q <= up_valid;
    end
  end

  // Payload registers only capture on a real transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      amt_q  <= '0;
      op_q   <= OP_ROL;
      err_q  <= 1'b0;
    end else if (load) begin
      data_q <= shifted;
      amt_q  <= up_amt;
      op_q   <= up_op;
      err_q  <= up_err;
    end
  end

  assign dn_valid = valid_q;
  assign dn_data  = data_q;
  assign dn_amt   = amt_q;
  assign dn_op    = op_q;
  assign dn_err   = err_q;

endmodule

// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - pipelined barrel shifter, one registered stage per amount bit
// Ports: clk, rst                 clock, async active-high reset
//        in_valid/in_ready        operation handshake; in_data, in_amt, in_op operands
//        out_valid/out_ready      result handshake; out_data result, out_err reserved-op flag
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  // Index k is the input side of stage k; index SHW is the pipeline output.
  logic [SHW:0]     valid_c;
  logic [SHW:0]     ready_c;
  logic [SHW:0]     err_c;
  logic [WIDTH-1:0] data_c [SHW+1];
  logic [SHW-1:0]   amt_c  [SHW+1];
  shift_op_t        op_c   [SHW+1];
  logic             unused_tail;

  assign valid_c[0] = in_valid;
  assign data_c[0]  = in_data;
  assign amt_c[0]   = in_amt;
  assign op_c[0]    = shift_op_t'(in_op);
  // Reserved ops are flagged once at entry; stages then pass the data untouched.
  assign err_c[0]   = is_reserved(shift_op_t'(in_op));
  assign in_ready   = ready_c[0];

  assign ready_c[SHW] = out_ready;
  assign out_valid    = valid_c[SHW];
  assign out_data     = data_c[SHW];
  assign out_err      = err_c[SHW];

  // Amount and op are not needed past the final stage.
  assign unused_tail = ^{amt_c[SHW], op_c[SHW]};

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (valid_c[k]),
      .up_ready (ready_c[k]),
      .up_data  (data_c[k]),
      .up_amt   (amt_c[k]),
      .up_op    (op_c[k]),
      .up_err   (err_c[k]),
      .dn_valid (valid_c[k+1]),
      .dn_ready (ready_c[k+1]),
      .dn_data  (data_c[k+1]),
      .dn_amt   (amt_c[k+1]),
      .dn_op    (op_c[k+1]),
      .dn_err   (err_c[k+1])
    );
  end

endmodule

// File: tb/tb_shift_pipe.sv
// tb/tb_shift_pipe.sv - scoreboard bench for shift_pipe at WIDTH=16 and WIDTH=32
module tb_shift_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
  logic [15:0] a_in_data, a_out_data;
  logic [3:0]  a_in_amt;
  logic [2:0]  a_in_op;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
  logic [31:0] b_in_data, b_out_data;
  logic [4:0]  b_in_amt;
  logic [2:0]  b_in_op;

  shift_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_amt(a_in_amt), .in_op(a_in_op),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_err(a_out_err)
  );

  shift_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_amt(b_in_amt), .in_op(b_in_op),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_err(b_out_err)
  );

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t q16[$];
  exp_t q32[$];
  int   errors = 0;
  int   checks = 0;
  int   seen16 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: each result bit is picked from its source bit by index arithmetic.
  function automatic logic [64:0] ref_model(logic [63:0] x, int amt, int op, int w);
    logic [63:0] r;
    r = '0;
    if (op > 4) return {1'b1, x};
    for (int i = 0; i < w; i++) begin
      case (op)
        0:       r[(i + amt) % w] = x[i];
        1:       if (i + amt < w) r[i + amt] = x[i];
        2:       r[i] = x[(i + amt) % w];
        3:       if (i + amt < w) r[i] = x[i + amt];
        default: r[i] = (i + amt < w) ? x[i + amt] : x[w-1];
      endcase
    end
    return {1'b0, r};
  endfunction

  // Monitors: pop and compare on every output transfer.
  always @(negedge clk) begin : mon16
    exp_t e;
    if (!rst && a_out_valid && a_out_ready) begin
      seen16++;
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected16: out_data %0h appeared with nothing expected", a_out_data);
      end else begin
        e = q16.pop_front();
        check("data16", {48'b0, a_out_data}, {48'b0, e.data[15:0]});
        check("err16", {63'b0, a_out_err}, {63'b0, e.err});
        if (e.lat) check("latency16", cyc - e.cyc, 4);
      end
    end
  end

  logic        hold32;
  logic [32:0] held32;
  initial hold32 = 1'b0;

  always @(negedge clk) begin : mon32
    exp_t e;
    if (rst) begin
      hold32 = 1'b0;
    end else begin
      if (hold32) check("hold32", {30'b0, b_out_valid, b_out_err, b_out_data}, {31'b0, 1'b1, held32});
      hold32 = b_out_valid && !b_out_ready;
      held32 = {b_out_err, b_out_data};
      if (b_out_valid && b_out_ready) begin
        if (q32.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected32: out_data %0h appeared with nothing expected", b_out_data);
        end else begin
          e = q32.pop_front();
          check("data32", {32'b0, b_out_data}, {32'b0, e.data[31:0]});
          check("err32", {63'b0, b_out_err}, {63'b0, e.err});
        end
      end
    end
  end

  // Drivers start at posedge+1 and return at posedge+1.
  task automatic send16(input logic [2:0] op, input logic [15:0] d, input logic [3:0] amt,
                        input logic [15:0] ed, input logic ee, input bit lat,
                        input int budget, output bit ok);
    exp_t e;
    a_in_valid = 1'b1;
    a_in_op    = op;
    a_in_data  = d;
    a_in_amt   = amt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (a_in_ready) begin
        e.data = {48'b0, ed};
        e.err  = ee;
        e.cyc  = cyc;
        e.lat  = lat;
        q16.push_back(e);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
      if (ok) break;
    end
    a_in_valid = 1'b0;
  endtask

  task automatic send16_model(input logic [2:0] op, input logic [15:0] d, input logic [3:0] amt,
                              input int budget, output bit ok);
    logic [64:0] r;
    r = ref_model({48'b0, d}, int'(amt), int'(op), 16);
    send16(op, d, amt, r[15:0], r[64], 1'b0, budget, ok);
  endtask

  task automatic send32(input int budget, output bit ok);
    exp_t        e;
    logic [64:0] r;
    b_in_valid = 1'b1;
    b_in_data  = $urandom;
    b_in_amt   = 5'($urandom_range(0, 31));
    b_in_op    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
    r = ref_model({32'b0, b_in_data}, int'(b_in_amt), int'(b_in_op), 32);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (b_in_ready) begin
        e.data = r[63:0];
        e.err  = r[64];
        e.cyc  = cyc;
        e.lat  = 1'b0;
        q32.push_back(e);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
      if (ok) break;
    end
    b_in_valid = 1'b0;
  endtask

  task automatic drain16();
    for (int i = 0; i < 100 && q16.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain16", q16.size(), 0);
  endtask

  task automatic one16(input logic [2:0] op, input logic [15:0] d, input logic [3:0] amt,
                       input logic [15:0] ed, input logic ee);
    bit ok;
    send16(op, d, amt, ed, ee, 1'b1, 5, ok);
    check("accept16", {63'b0, ok}, 1);
    drain16();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int          acc;
    int          snap;
    bit          rnd_done;
    logic [15:0] held;
    logic [15:0] bp_d [6];
    logic [3:0]  bp_a [6];
    logic [2:0]  bp_o [6];
    logic [64:0] r0;

    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_amt = '0; a_in_op = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_amt = '0; b_in_op = '0; b_out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_out_valid", {63'b0, a_out_valid}, 0);
    check("rst_out_data", {48'b0, a_out_data}, 0);
    check("rst_out_err", {63'b0, a_out_err}, 0);
    check("rst_in_ready", {63'b0, a_in_ready}, 1);
    check("rst_in_ready32", {63'b0, b_in_ready}, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    one16(3'b000, 16'h8001, 4'd1,  16'h0003, 1'b0);
    one16(3'b010, 16'h0001, 4'd1,  16'h8000, 1'b0);
    one16(3'b001, 16'h00FF, 4'd4,  16'h0FF0, 1'b0);
    one16(3'b011, 16'h8000, 4'd15, 16'h0001, 1'b0);
    one16(3'b100, 16'h8000, 4'd4,  16'hF800, 1'b0);
    one16(3'b100, 16'h1234, 4'd0,  16'h1234, 1'b0);
    one16(3'b110, 16'hBEEF, 4'd5,  16'hBEEF, 1'b1);

    // Back-pressure: six ops against a stalled output.
    for (int k = 0; k < 6; k++) begin
      bp_d[k] = 16'($urandom);
      bp_a[k] = 4'($urandom_range(1, 15));
      bp_o[k] = 3'($urandom_range(0, 4));
    end
    r0 = ref_model({48'b0, bp_d[0]}, int'(bp_a[0]), int'(bp_o[0]), 16);
    a_out_ready = 1'b0;
    acc = 0;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          send16_model(bp_o[k], bp_d[k], bp_a[k], 60, ok);
          check("bp_accept", {63'b0, ok}, 1);
          if (ok) acc++;
        end
      end
      begin
        repeat (8) @(posedge clk);
        #2;
        check("bp_count", acc, 4);
        check("bp_in_ready", {63'b0, a_in_ready}, 0);
        check("bp_out_valid", {63'b0, a_out_valid}, 1);
        check("bp_head", {48'b0, a_out_data}, {48'b0, r0[15:0]});
        held = a_out_data;
        repeat (2) @(posedge clk);
        #2;
        check("bp_stable", {48'b0, a_out_data}, {48'b0, held});
        a_out_ready = 1'b1;
        #1;
        check("bp_ready_follow", {63'b0, a_in_ready}, 1);
      end
    join
    drain16();

    // Bubbles: alternating input with a stalled output still fills every slot.
    a_out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send16_model(3'($urandom_range(0, 4)), 16'($urandom), 4'($urandom), 1, ok);
      check("bub_accept", {63'b0, ok}, 1);
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    check("bub_full", {63'b0, a_in_ready}, 0);
    a_out_ready = 1'b1;
    drain16();

    // Reset with three ops in flight, one already presented at the output.
    a_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send16_model(3'b001, 16'($urandom), 4'($urandom), 5, ok);
      check("rstf_accept", {63'b0, ok}, 1);
    end
    repeat (2) @(posedge clk);
    #1;
    check("rstf_pre_valid", {63'b0, a_out_valid}, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rstf_out_valid", {63'b0, a_out_valid}, 0);
    check("rstf_in_ready", {63'b0, a_in_ready}, 1);
    q16.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_out_ready = 1'b1;
    snap = seen16;
    repeat (8) @(posedge clk);
    #1;
    check("rstf_no_stale", seen16 - snap, 0);
    one16(3'b001, 16'h0001, 4'd3, 16'h0008, 1'b0);

    // WIDTH=32 random run with random back-pressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 10000; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send32(200, ok);
          if (!ok) check("rand_accept", {63'b0, ok}, 1);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          b_out_ready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    b_out_ready = 1'b1;
    for (int i = 0; i < 200 && q32.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain32", q32.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
